// File: rtl/juego_led_pkg.sv
// Shared definitions for the tug-of-war LED game core.
//   estadoT        : game FSM state encoding
//   NumLedsDefault : default LED count for the game core
package juego_led_pkg;

  localparam int unsigned NumLedsDefault = 8;

  typedef enum logic [1:0] {
    JUGANDO = 2'd0,
    GANA_A  = 2'd1,
    GANA_B  = 2'd2,
    APAGADO = 2'd3
  } estadoT;

endpackage

// File: rtl/sincroniza_boton.sv
// Button conditioner: two-flop synchroniser followed by a delay flop, producing a
// single-cycle pulse on each rising edge of the synchronised button.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears all three flops
//   boton : asynchronous active-high button
//   pulso : one-cycle pulse, high for the cycle after the synchronised rise
module sincroniza_boton (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic pulso
);

  logic s1Q, s2Q, s3Q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Q <= 1'b0;
      s2Q <= 1'b0;
      s3Q <= 1'b0;
    end else begin
      s1Q <= boton;
      s2Q <= s1Q;
      s3Q <= s2Q;
    end
  end

  assign pulso = s2Q & ~s3Q;

endmodule

// File: rtl/juego_led_contador.sv
// Tug-of-war LED game core. Player A pushes the lit LED up, player B pushes it down;
// reaching either end declares a winner, whose LED blinks for a display period
// before the block raises Apagar and waits for resetContador.
//   clk           : system clock, rising edge
//   reset         : synchronous active-high global reset (also clears button syncs)
//   resetContador : synchronous active-high game clear from the reset-decode stage
//   botonA/botonB : asynchronous active-high player buttons
//   leds          : registered LED drive
//   posicion      : registered current position
//   GanadorA/B    : registered winner flags
//   Apagar        : registered display-over flag
module juego_led_contador
  import juego_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = NumLedsDefault,
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned BLINK_HALF  = 6_250_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        resetContador,
  input  logic                        botonA,
  input  logic                        botonB,
  output logic [NUM_LEDS-1:0]         leds,
  output logic [$clog2(NUM_LEDS)-1:0] posicion,
  output logic                        GanadorA,
  output logic                        GanadorB,
  output logic                        Apagar
);

  localparam int unsigned PosW   = $clog2(NUM_LEDS);
  localparam int unsigned ShowW  = $clog2(SHOW_CYCLES + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);

  localparam logic [PosW-1:0]   PosMax    = PosW'(NUM_LEDS - 1);
  localparam logic [PosW-1:0]   PosInicio = PosW'(NUM_LEDS / 2);
  localparam logic [ShowW-1:0]  ShowFin   = ShowW'(SHOW_CYCLES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

  function automatic logic [NUM_LEDS-1:0] oneHot(input logic [PosW-1:0] p);
    logic [NUM_LEDS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  logic pulsoA, pulsoB;

  sincroniza_boton uSincA (
    .clk   (clk),
    .reset (reset),
    .boton (botonA),
    .pulso (pulsoA)
  );

  sincroniza_boton uSincB (
    .clk   (clk),
    .reset (reset),
    .boton (botonB),
    .pulso (pulsoB)
  );

  estadoT              estadoQ, estadoD;
  logic [PosW-1:0]     posicionQ, posicionD;
  logic [NUM_LEDS-1:0] ledsQ, ledsD;
  logic                ganadorAQ, ganadorAD;
  logic                ganadorBQ, ganadorBD;
  logic                apagarQ, apagarD;
  logic [ShowW-1:0]    showQ, showD;
  logic [BlinkW-1:0]   blinkQ, blinkD;
  logic                faseQ, faseD;

  always_comb begin
    estadoD   = estadoQ;
    posicionD = posicionQ;
    ledsD     = ledsQ;
    ganadorAD = ganadorAQ;
    ganadorBD = ganadorBQ;
    apagarD   = apagarQ;
    showD     = showQ;
    blinkD    = blinkQ;
    faseD     = faseQ;

    case (estadoQ)
      JUGANDO: begin
        // Simultaneous edges cancel. The end guards never trigger in practice
        // because reaching an end leaves this state.
        if (pulsoA && !pulsoB && posicionQ != PosMax) begin
          posicionD = posicionQ + PosW'(1);
        end else if (pulsoB && !pulsoA && posicionQ != '0) begin
          posicionD = posicionQ - PosW'(1);
        end
        ledsD = oneHot(posicionD);
        if (posicionD == PosMax) begin
          estadoD   = GANA_A;
          ganadorAD = 1'b1;
          showD     = '0;
          blinkD    = '0;
          faseD     = 1'b1;
        end else if (posicionD == '0) begin
          estadoD   = GANA_B;
          ganadorBD = 1'b1;
          showD     = '0;
          blinkD    = '0;
          faseD     = 1'b1;
        end
      end

      GANA_A, GANA_B: begin
        // The counter is 0 on the entry cycle; the display ends one cycle after
        // it has spent a cycle at SHOW_CYCLES-1, i.e. once it reads SHOW_CYCLES.
        if (showQ == ShowFin) begin
          estadoD = APAGADO;
          apagarD = 1'b1;
          ledsD   = '0;
        end else begin
          showD = showQ + ShowW'(1);
          if (blinkQ == BlinkLast) begin
            blinkD = '0;
            faseD  = ~faseQ;
          end else begin
            blinkD = blinkQ + BlinkW'(1);
          end
          ledsD = faseD ? oneHot(posicionQ) : '0;
        end
      end

      APAGADO: begin
        ledsD   = '0;
        apagarD = 1'b1;
      end

      default: begin
        estadoD = JUGANDO;
      end
    endcase
  end

  // resetContador shares the reset values but leaves the synchronisers alone, so a
  // button held across a game clear does not register a new press.
  always_ff @(posedge clk) begin
    if (reset || resetContador) begin
      estadoQ   <= JUGANDO;
      posicionQ <= PosInicio;
      ledsQ     <= oneHot(PosInicio);
      ganadorAQ <= 1'b0;
      ganadorBQ <= 1'b0;
      apagarQ   <= 1'b0;
      showQ     <= '0;
      blinkQ    <= '0;
      faseQ     <= 1'b1;
    end else begin
      estadoQ   <= estadoD;
      posicionQ <= posicionD;
      ledsQ     <= ledsD;
      ganadorAQ <= ganadorAD;
      ganadorBQ <= ganadorBD;
      apagarQ   <= apagarD;
      showQ     <= showD;
      blinkQ    <= blinkD;
      faseQ     <= faseD;
    end
  end

  assign leds     = ledsQ;
  assign posicion = posicionQ;
  assign GanadorA = ganadorAQ;
  assign GanadorB = ganadorBQ;
  assign Apagar   = apagarQ;

endmodule

// File: tb/tb_juego_led_contador.sv
module tb_juego_led_contador;

  localparam int unsigned N  = 8;
  localparam int unsigned SC = 16;
  localparam int unsigned BH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         resetContador = 1'b0;
  logic         botonA = 1'b0;
  logic         botonB = 1'b0;
  logic [N-1:0] leds;
  logic [2:0]   posicion;
  logic         GanadorA, GanadorB, Apagar;

  int nVec = 0;
  int nMis = 0;

  // Reference model: position, winner (0 none, 1 A, 2 B), cycles since the win,
  // and the last three button samples (index 0 newest).
  int mPos = N / 2;
  int mWin = 0;
  int mT   = 0;
  bit hA[3];
  bit hB[3];

  always #5 clk = ~clk;

  juego_led_contador #(
    .NUM_LEDS    (N),
    .SHOW_CYCLES (SC),
    .BLINK_HALF  (BH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .resetContador (resetContador),
    .botonA        (botonA),
    .botonB        (botonB),
    .leds          (leds),
    .posicion      (posicion),
    .GanadorA      (GanadorA),
    .GanadorB      (GanadorB),
    .Apagar        (Apagar)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the game rules, using the inputs present at that edge.
  task automatic modelo();
    bit evA, evB;
    // A press sampled at edge k-2 (and low at k-3) acts at edge k.
    evA = hA[1] && !hA[2];
    evB = hB[1] && !hB[2];
    if (reset) begin
      hA = '{default: 1'b0};
      hB = '{default: 1'b0};
    end else begin
      hA[2] = hA[1]; hA[1] = hA[0]; hA[0] = botonA;
      hB[2] = hB[1]; hB[1] = hB[0]; hB[0] = botonB;
    end
    if (reset || resetContador) begin
      mPos = N / 2;
      mWin = 0;
      mT   = 0;
    end else if (mWin == 0) begin
      if (evA && !evB) mPos++;
      else if (evB && !evA) mPos--;
      if (mPos == N - 1) mWin = 1;
      else if (mPos == 0) mWin = 2;
      mT = 0;
    end else if (mT <= SC) begin
      mT++;
    end
  endtask

  task automatic paso(input string tag);
    logic [N-1:0] uno;
    logic [N-1:0] eLeds;
    bit           luce;
    @(posedge clk);
    modelo();
    #1;
    uno   = 1;
    luce  = (mWin == 0) || (mT <= SC && ((mT / BH) % 2 == 0));
    eLeds = luce ? (uno << mPos) : '0;
    chk({tag, ".posicion"}, 32'(posicion), 32'(mPos));
    chk({tag, ".leds"}, 32'(leds), 32'(eLeds));
    chk({tag, ".GanadorA"}, 32'(GanadorA), 32'(mWin == 1));
    chk({tag, ".GanadorB"}, 32'(GanadorB), 32'(mWin == 2));
    chk({tag, ".Apagar"}, 32'(Apagar), 32'(mWin != 0 && mT > SC));
    chk({tag, ".exclusivos"}, 32'(GanadorA & GanadorB), 32'd0);
  endtask

  task automatic pulsar(input string tag, input bit a, input bit b, input int largo);
    botonA = a;
    botonB = b;
    for (int i = 0; i < largo; i++) paso(tag);
    botonA = 1'b0;
    botonB = 1'b0;
    for (int i = 0; i < 3; i++) paso(tag);
  endtask

  task automatic reiniciar(input string tag);
    reset = 1'b1;
    paso(tag);
    paso(tag);
    reset = 1'b0;
  endtask

  int  apagarVisto;
  bit  limpio;
  int  victorias;

  initial begin
    // 1: reset values, then single-cycle A pulse moves to 5 two edges later.
    reiniciar("reset");
    chk("reset.leds_const", 32'(leds), 32'h10);
    botonA = 1'b1;
    paso("pulsoA.N");
    botonA = 1'b0;
    paso("pulsoA.N1");
    paso("pulsoA.N2");
    chk("pulsoA.pos5", 32'(posicion), 32'd5);
    chk("pulsoA.leds", 32'(leds), 32'h20);
    paso("pulsoA.post");

    // 2: three A presses win; held button during the display is ignored.
    reiniciar("r2");
    for (int i = 0; i < 3; i++) pulsar("ganaA", 1'b1, 1'b0, 2);
    chk("ganaA.flag", 32'(GanadorA), 32'd1);
    botonA = 1'b1;
    for (int i = 0; i < 20; i++) paso("ganaA.mantiene");
    botonA = 1'b0;
    for (int i = 0; i < 5; i++) paso("ganaA.apagado");
    chk("ganaA.apagar", 32'(Apagar), 32'd1);

    // 3: four B presses win; resetContador in APAGADO returns to the start.
    reiniciar("r3");
    for (int i = 0; i < 4; i++) pulsar("ganaB", 1'b0, 1'b1, 1);
    for (int i = 0; i < 20; i++) paso("ganaB.espera");
    chk("ganaB.apagar", 32'(Apagar), 32'd1);
    resetContador = 1'b1;
    paso("ganaB.clear");
    resetContador = 1'b0;
    chk("ganaB.clear_pos", 32'(posicion), 32'd4);
    paso("ganaB.post");

    // 4: simultaneous presses cancel; a long A hold moves once.
    reiniciar("r4");
    pulsar("ambos", 1'b1, 1'b1, 2);
    chk("ambos.pos", 32'(posicion), 32'd4);
    pulsar("largoA", 1'b1, 1'b0, 50);
    chk("largoA.pos", 32'(posicion), 32'd5);

    // 5: game clear at position 6 with A held, then both resets together.
    pulsar("a6", 1'b1, 1'b0, 1);
    botonA = 1'b1;
    for (int i = 0; i < 3; i++) paso("mantiene6");
    resetContador = 1'b1;
    paso("clear6");
    resetContador = 1'b0;
    for (int i = 0; i < 6; i++) paso("clear6.post");
    chk("clear6.pos", 32'(posicion), 32'd4);
    botonA = 1'b0;
    pulsar("a5", 1'b1, 1'b0, 1);
    reset = 1'b1;
    resetContador = 1'b1;
    paso("ambosResets");
    reset = 1'b0;
    resetContador = 1'b0;
    paso("ambosResets.post");

    // 6: closed loop with the reset-decode stage, directed win first.
    reiniciar("r6");
    for (int i = 0; i < 3; i++) pulsar("lazo", 1'b1, 1'b0, 1);
    apagarVisto = 0;
    limpio = 1'b0;
    for (int i = 0; i < 40 && !limpio; i++) begin
      resetContador = Apagar & (GanadorA | GanadorB);
      if (Apagar) apagarVisto++;
      paso("lazo.decode");
      if (apagarVisto > 0 && !Apagar && !GanadorA) limpio = 1'b1;
    end
    resetContador = 1'b0;
    chk("lazo.retorno", 32'(limpio), 32'd1);
    chk("lazo.apagar1", 32'(apagarVisto), 32'd1);

    // Randomized presses, biased towards A so games actually finish.
    victorias = 0;
    for (int i = 0; i < 1500; i++) begin
      resetContador = Apagar & (GanadorA | GanadorB);
      if (resetContador) victorias++;
      botonA = ($urandom_range(0, 3) == 0);
      botonB = ($urandom_range(0, 6) == 0);
      paso("aleatorio");
    end
    resetContador = 1'b0;
    botonA = 1'b0;
    botonB = 1'b0;
    paso("fin");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/juego_led_contador.md
Name: juego_led_contador

Overview:
- Tug-of-war LED game core. Two player buttons move a one-hot LED position, and reaching either end declares a winner.
- After a fixed display period the block raises Apagar and holds until cleared.
- Sits directly upstream of the game reset-decode stage. It produces GanadorA, GanadorB and Apagar, and consumes the resetContador that stage returns.

Parameters:
- NUM_LEDS, 8: LED count; must be ≥4 and even. Start position is NUM_LEDS/2.
- SHOW_CYCLES, 50_000_000: cycles the winner display lasts before Apagar.
- BLINK_HALF, 6_250_000: half-period in cycles of the winner LED blink; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high global reset.
- resetContador  in  1  synchronous, active-high game clear from the reset-decode stage.
- botonA  in  1  player A button, asynchronous, active-high.
- botonB  in  1  player B button, asynchronous, active-high.
- leds  out  NUM_LEDS  LED drive.
- posicion  out  $clog2(NUM_LEDS)  current position.
- GanadorA  out  1  player A has won.
- GanadorB  out  1  player B has won.
- Apagar  out  1  display period over, LEDs off.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. resetContador is also synchronous and active-high. reset has priority over resetContador.
- Reset values (both resets): state JUGANDO, posicion=NUM_LEDS/2, leds=one-hot(NUM_LEDS/2), GanadorA=GanadorB=Apagar=0, show and blink counters=0, blink phase=1.
  - reset also clears the button synchronisers.
  - resetContador leaves the synchronisers unchanged, so a button held through the clear does not produce a fresh edge.
- Button path, per button:
  - Two-flop synchroniser s1→s2, plus delay flop s3.
  - edge = s2 & ~s3.
  - A button first sampled high at clock edge N updates posicion at edge N+2.
  - One move per press, regardless of press length.
- FSM, states JUGANDO, GANA_A, GANA_B, APAGADO. All outputs are registered.
- JUGANDO:
  - edgeA & ~edgeB: posicion+1.
  - edgeB & ~edgeA: posicion−1.
  - Both edges in the same cycle: no move.
  - posicion becoming NUM_LEDS−1 → GANA_A, GanadorA=1 in the same cycle.
  - posicion becoming 0 → GANA_B, GanadorB=1 in the same cycle.
  - leds=one-hot(posicion).
- GANA_A / GANA_B:
  - Buttons are ignored and posicion is frozen.
  - Blink phase starts at 1 on entry and toggles every BLINK_HALF cycles. leds=one-hot(posicion) when phase=1, else 0.
  - Show counter counts 0..SHOW_CYCLES−1. On the cycle after it reaches SHOW_CYCLES−1: go to APAGADO, Apagar=1.
- APAGADO:
  - leds=0, Apagar=1, and the GanadorX flag stays asserted.
  - The downstream stage decodes Apagar&GanadorX into resetContador, which returns the block to JUGANDO on the next edge.
  - The block holds indefinitely if resetContador never arrives.
- Invariants:
  - GanadorA and GanadorB are never both 1.
  - posicion never wraps; it stays within 0..NUM_LEDS−1 because movement stops at the ends.
  - Apagar=1 implies exactly one Ganador flag is 1.
- resetContador mid-game (any state) returns to the reset values on the next edge. Winner and show progress are discarded.
- Counter widths: $clog2(SHOW_CYCLES+1) and $clog2(BLINK_HALF+1). No overflow is possible because counters clear on state entry.

Decomposition:
- Shared package (juego_led_pkg):
  - state encoding constants JUGANDO=2'd0, GANA_A=2'd1, GANA_B=2'd2, APAGADO=2'd3.
  - default NUM_LEDS.
- One natural sub-module: sincroniza_boton (2-flop sync + edge detect, sync reset), instantiated twice.
- FSM, position and counters stay in the top module.

Test Plan (NUM_LEDS=8, SHOW_CYCLES=16, BLINK_HALF=4):
1. reset for 2 cycles → posicion=4, leds=8'b0001_0000, all flags 0. Pulse botonA high for 1 cycle at edge N → posicion=5 after edge N+2, leds=8'b0010_0000.
2. 3 separate A presses from start → posicion=7, GanadorA=1 on the same edge. Then leds alternate 8'b1000_0000 / 0 every 4 cycles. Apagar=1 and leds=0 17 cycles after the win. Hold botonA for 20 cycles during the win → no change.
3. 4 separate B presses → posicion=0, GanadorB=1. Then drive resetContador=1 in APAGADO → next edge posicion=4, GanadorB=0, Apagar=0.
4. botonA and botonB rise in the same cycle → posicion stays 4. A held high for 50 cycles → exactly one move, to 5.
5. resetContador at posicion=6 mid-game with botonA held → posicion=4 and no spurious move afterwards. reset and resetContador both asserted → reset values.
6. Closed loop with the reset-decode stage: A wins → Apagar then resetContador → JUGANDO within 1 cycle of Apagar. Check the invariant that GanadorA&GanadorB is never 1 across randomized presses.
